// File: rtl/cb_heep_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : cb_heep_boot_ctrl_if
// Brief   : Zero-wait register bus between a host and the boot controller.
// Revision: 1.0 - initial release
// ============================================================================
interface cb_heep_boot_ctrl_if;
    logic        reg_valid_i;
    logic        reg_write_i;
    logic [7:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic        reg_ready_o;
    logic [31:0] reg_rdata_o;
    logic        reg_error_o;

    modport master (
        output reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i,
        input  reg_ready_o, reg_rdata_o, reg_error_o
    );

    modport slave (
        input  reg_valid_i, reg_write_i, reg_addr_i, reg_wdata_i,
        output reg_ready_o, reg_rdata_o, reg_error_o
    );
endinterface
`default_nettype wire

// File: rtl/cb_heep_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cb_heep_boot_ctrl
// Brief   : Per-core boot address registers and exit-loop handshake with timeout.
// Revision: 1.0 - initial release
// ============================================================================
module cb_heep_boot_ctrl #(
    parameter int          NUM_CORES     = 4,
    parameter int          TIMEOUT_W     = 16,
    parameter logic [31:0] BOOT_ADDR_RST = 32'h0000_0180
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_i,
    cb_heep_boot_ctrl_if.slave           bus,
    output logic [32*NUM_CORES-1:0]      boot_addr_o,
    output logic [NUM_CORES-1:0]         exit_loop_o,
    input  wire logic [NUM_CORES-1:0]    exit_ack_i,
    output logic                         irq_o
);

    localparam logic [7:0] C_ADDR_CTRL    = 8'h00;
    localparam logic [7:0] C_ADDR_STATUS  = 8'h04;
    localparam logic [7:0] C_ADDR_TIMEOUT = 8'h08;
    localparam logic [7:0] C_ADDR_IRQ_EN  = 8'h0C;
    localparam logic [7:0] C_ADDR_BOOT0   = 8'h10;

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_REQ  = 1'b1;

    logic [TIMEOUT_W-1:0] r_timeout;
    logic                 r_irq_en;
    logic [NUM_CORES-1:0] r_done;
    logic [NUM_CORES-1:0] r_tmo;
    logic [31:0]          r_boot [NUM_CORES];

    logic [NUM_CORES-1:0] w_boot_sel;
    logic                 w_is_ctrl;
    logic                 w_is_status;
    logic                 w_is_timeout;
    logic                 w_is_irq_en;
    logic                 w_mapped;
    logic                 w_error;
    logic                 w_wr;
    logic [NUM_CORES-1:0] w_pending;
    logic [NUM_CORES-1:0] w_set_done;
    logic [NUM_CORES-1:0] w_set_tmo;
    logic [NUM_CORES-1:0] w_clr_done;
    logic [NUM_CORES-1:0] w_clr_tmo;
    logic [31:0]          w_status;
    logic [31:0]          w_rdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    always_comb begin
        w_boot_sel = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_boot_sel[i] = (bus.reg_addr_i == 8'(int'(C_ADDR_BOOT0) + 4 * i));
        end
    end

    assign w_is_ctrl    = (bus.reg_addr_i == C_ADDR_CTRL);
    assign w_is_status  = (bus.reg_addr_i == C_ADDR_STATUS);
    assign w_is_timeout = (bus.reg_addr_i == C_ADDR_TIMEOUT);
    assign w_is_irq_en  = (bus.reg_addr_i == C_ADDR_IRQ_EN);
    assign w_mapped     = w_is_ctrl | w_is_status | w_is_timeout | w_is_irq_en | (|w_boot_sel);

    // CTRL is write-only, so a read of it is an error like an unmapped access
    assign w_error = bus.reg_valid_i & (~w_mapped | (bus.reg_addr_i[1:0] != 2'b00) |
                                        (w_is_ctrl & ~bus.reg_write_i));
    assign w_wr    = bus.reg_valid_i & bus.reg_write_i & ~w_error;

    assign w_clr_done = (w_wr && w_is_status) ? bus.reg_wdata_i[8 +: NUM_CORES]  : '0;
    assign w_clr_tmo  = (w_wr && w_is_status) ? bus.reg_wdata_i[16 +: NUM_CORES] : '0;

    // ------------------------------------------------------------------
    // Per-core exit-loop handshake FSM
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        logic [0:0]           r_state;
        logic [0:0]           w_state_nxt;
        logic [TIMEOUT_W-1:0] r_cnt;
        logic [TIMEOUT_W-1:0] w_cnt_nxt;
        logic                 w_start;
        logic                 w_expire;
        logic                 w_exit;
        logic                 w_done_set;
        logic                 w_tmo_set;

        assign w_start  = w_wr & w_is_ctrl & bus.reg_wdata_i[gi];
        assign w_expire = (r_timeout != '0) && (r_cnt == r_timeout - TIMEOUT_W'(1));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_state <= C_ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                C_ST_IDLE: begin
                    if (w_start) begin
                        w_state_nxt = C_ST_REQ;
                        w_cnt_nxt   = '0;
                    end
                end
                C_ST_REQ: begin
                    if (exit_ack_i[gi] || w_expire) begin
                        w_state_nxt = C_ST_IDLE;
                    end else if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + TIMEOUT_W'(1);
                    end
                end
                default: w_state_nxt = C_ST_IDLE;
            endcase
        end

        // Ack takes priority over an expiry landing on the same cycle
        always_comb begin
            w_exit     = (r_state == C_ST_REQ);
            w_done_set = (r_state == C_ST_REQ) &  exit_ack_i[gi];
            w_tmo_set  = (r_state == C_ST_REQ) & ~exit_ack_i[gi] & w_expire;
        end

        assign exit_loop_o[gi] = w_exit;
        assign w_pending[gi]   = w_exit;
        assign w_set_done[gi]  = w_done_set;
        assign w_set_tmo[gi]   = w_tmo_set;
    end

    // ------------------------------------------------------------------
    // Configuration and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout <= '0;
            r_irq_en  <= 1'b0;
            r_done    <= '0;
            r_tmo     <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_boot[i] <= BOOT_ADDR_RST;
            end
        end else begin
            if (w_wr && w_is_timeout) begin
                r_timeout <= bus.reg_wdata_i[TIMEOUT_W-1:0];
            end
            if (w_wr && w_is_irq_en) begin
                r_irq_en <= bus.reg_wdata_i[0];
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_wr && w_boot_sel[i]) begin
                    r_boot[i] <= bus.reg_wdata_i;
                end
            end
            // Hardware set dominates a simultaneous W1C
            r_done <= (r_done & ~w_clr_done) | w_set_done;
            r_tmo  <= (r_tmo  & ~w_clr_tmo)  | w_set_tmo;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        w_status                   = '0;
        w_status[0 +: NUM_CORES]   = w_pending;
        w_status[8 +: NUM_CORES]   = r_done;
        w_status[16 +: NUM_CORES]  = r_tmo;
        w_rdata                    = '0;
        if (bus.reg_valid_i && !bus.reg_write_i && !w_error) begin
            if (w_is_status) begin
                w_rdata = w_status;
            end else if (w_is_timeout) begin
                w_rdata = 32'(r_timeout);
            end else if (w_is_irq_en) begin
                w_rdata = {31'b0, r_irq_en};
            end else begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (w_boot_sel[i]) begin
                        w_rdata = r_boot[i];
                    end
                end
            end
        end
    end

    assign bus.reg_ready_o = bus.reg_valid_i;
    assign bus.reg_rdata_o = w_rdata;
    assign bus.reg_error_o = w_error;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_boot
        assign boot_addr_o[32*gi +: 32] = r_boot[gi];
    end

    assign irq_o = r_irq_en & ((|r_done) | (|r_tmo));

endmodule
`default_nettype wire

// File: doc/cb_heep_boot_ctrl.md
CB_HEEP_BOOT_CTRL -- requirements
Module: cb_heep_boot_ctrl

Interface
REQ-001 Parameter NUM_CORES, default 4, number of controlled cores; legal range 1..8.
REQ-002 Parameter TIMEOUT_W, default 16, width of the exit-handshake timeout counter and limit register.
REQ-003 Parameter BOOT_ADDR_RST, default 32'h0000_0180, reset value of every BOOT_ADDR register.
REQ-004 clk_i  in  1  single clock, all state updates on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 reg_valid_i  in  1  bus access request.
REQ-007 reg_write_i  in  1  1 = write, 0 = read.
REQ-008 reg_addr_i  in  8  byte address.
REQ-009 reg_wdata_i  in  32  write data.
REQ-010 reg_ready_o  out  1  access complete.
REQ-011 reg_rdata_o  out  32  read data.
REQ-012 reg_error_o  out  1  access error.
REQ-013 boot_addr_o  out  32*NUM_CORES  per-core boot address; core i in bits [32i+31:32i].
REQ-014 exit_loop_o  out  NUM_CORES  per-core exit-loop request level.
REQ-015 exit_ack_i  in  NUM_CORES  per-core exit-loop acknowledge.
REQ-016 irq_o  out  1  summary interrupt.

Function
REQ-017 Register map: 0x00 CTRL (WO, write 1 to bit i requests exit for core i); 0x04 STATUS (RW1C); 0x08 TIMEOUT (RW, low TIMEOUT_W bits); 0x0C IRQ_EN (RW, bit0); 0x10+4i BOOT_ADDR[i] (RW, i < NUM_CORES).
REQ-018 STATUS layout: bit i = pending[i] (RO), bit 8+i = done[i] (W1C), bit 16+i = timeout[i] (W1C); unused bits read 0.
REQ-019 Bus is zero-wait: reg_ready_o = reg_valid_i combinationally; reg_rdata_o valid in the same cycle; write takes effect at the next rising edge.
REQ-020 reg_error_o = reg_valid_i and (address unmapped, address[1:0] != 0, or write to CTRL-read / read of CTRL); erroring writes change no state; erroring reads return 0.
REQ-021 Reads of CTRL return 0 with error; reads of any other mapped register return its current value, zero-extended.
REQ-022 Each core owns an independent FSM with states IDLE and REQ.
REQ-023 IDLE -> REQ when CTRL bit i written 1; counter[i] cleared to 0; pending[i] = 1.
REQ-024 In REQ, exit_loop_o[i] = 1; counter[i] increments by 1 per cycle, saturating at all-ones.
REQ-025 REQ -> IDLE when exit_ack_i[i] = 1; done[i] set the same edge; exit_loop_o[i] drops the following cycle.
REQ-026 REQ -> IDLE when TIMEOUT != 0 and counter[i] == TIMEOUT - 1 with no ack; timeout[i] set; TIMEOUT = 0 disables timeout (wait forever).
REQ-027 Ack and timeout in the same cycle: ack wins, only done[i] set.
REQ-028 CTRL write to a core already in REQ is ignored (counter not restarted).
REQ-029 exit_ack_i[i] in IDLE is ignored.
REQ-030 W1C and hardware set of the same STATUS bit in the same cycle: set wins.
REQ-031 Writing TIMEOUT while a core is in REQ applies to the next comparison cycle.
REQ-032 irq_o = IRQ_EN[0] and OR of all done and timeout bits, registered-free combinational.
REQ-033 boot_addr_o mirrors BOOT_ADDR registers; BOOT_ADDR writes take effect regardless of FSM state.

Reset
REQ-034 While rst_i = 1: all FSMs IDLE, counters 0, STATUS 0, TIMEOUT 0, IRQ_EN 0, BOOT_ADDR[i] = BOOT_ADDR_RST, exit_loop_o = 0, irq_o = 0.
REQ-035 Reset asserted mid-handshake returns the core to IDLE immediately (asynchronously) with no done/timeout flag.

Verification
REQ-036 Write CTRL=0x1, ack core 0 after 5 cycles -> exit_loop_o[0] high 5 cycles, STATUS = 0x0000_0100, pending cleared.
REQ-037 TIMEOUT=4, CTRL=0x2, no ack -> exit_loop_o[1] high exactly 4 cycles, STATUS bit 17 set; IRQ_EN=1 -> irq_o=1; write STATUS=0x0002_0000 -> irq_o=0.
REQ-038 TIMEOUT=3, ack core 0 on the timeout cycle -> only bit 8 set, bit 16 clear.
REQ-039 Read 0x10+4*NUM_CORES and read 0x00 -> reg_error_o=1, rdata=0; write 0x02 -> error, no state change.
REQ-040 Write BOOT_ADDR[2]=0x2000_0000, assert rst_i mid-REQ on core 2 -> boot_addr_o core 2 = BOOT_ADDR_RST, exit_loop_o=0, STATUS=0.
